sram_ctrl: RTL and testbench
============================

# sram_ctrl

- Parametrised, clocked bridge between the CPU memory stage and the external 16-bit asynchronous SRAM.
- Converts one CPU_DW-wide read or write request into BEATS = CPU_DW/16 sequential halfword accesses, each held for WAIT_CYCLES+1 clocks.
- Honours per-byte write enables through SRAM_UB_N/SRAM_LB_N.
- Holds `ready` low so the pipeline freezes until the access completes.

## Interface
Parameters:
- CPU_DW, 32, CPU data width; multiple of 16, 16..128
- SRAM_AW, 18, SRAM halfword address width
- WAIT_CYCLES, 5, extra hold cycles per beat; must be ≥1
- ADDR_BASE, 1024, CPU byte address that maps to SRAM halfword 0

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write request, held until ready
- rd_en  in  1  read request, held until ready
- address  in  32  CPU byte address
- wr_data  in  CPU_DW  write data
- byte_en  in  CPU_DW/8  write byte enables, bit i ↔ wr_data[8i+7:8i]
- rd_data  out  CPU_DW  read data, valid while ready is high in DONE
- ready  out  1  high = no pending access / access complete
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  SRAM_AW  SRAM halfword address
- SRAM_UB_N, SRAM_LB_N  out  1  byte masks, active low
- SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1  write/chip/output enables, active low

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS when rd_en or wr_en is sampled high. On that edge, latch the following into registers: op, address, wr_data, byte_en; clear beat counter k and wait counter w.
- If rd_en and wr_en are both high, the write wins. This is a protocol violation; flag it with a simulation assertion.
- ACCESS: beat k spans WAIT_CYCLES+1 cycles, with w counting 0..WAIT_CYCLES.
  - w==WAIT_CYCLES and k<BEATS-1: k++, w=0.
  - w==WAIT_CYCLES and k==BEATS-1: go to DONE.
- DONE → IDLE unconditionally after one cycle.
- Address map:
  - word index = (address − ADDR_BASE) >> log2(CPU_DW/8).
  - SRAM_ADDR = word index·BEATS + k, truncated to SRAM_AW bits (wrap-around, no error).
  - address low bits below the word size are ignored.
- Beat order: beat k carries CPU bits [16k+15:16k]; the lowest halfword goes to the lowest SRAM address.
- Read beat:
  - CE_N=0, OE_N=0, WE_N=1, UB_N=LB_N=0, SRAM_DQ released (Z).
  - At w==WAIT_CYCLES, SRAM_DQ is registered into rd_data[16k+15:16k].
- Write beat:
  - CE_N=0, OE_N=1, SRAM_DQ driven with wr_data[16k+15:16k] for all cycles of the beat.
  - WE_N=0 for w<WAIT_CYCLES and WE_N=1 at w==WAIT_CYCLES (data hold).
  - LB_N=~byte_en[2k], UB_N=~byte_en[2k+1].
  - A beat with both enables 0 still runs its full duration; the SRAM contents are unchanged.
- Outside ACCESS: CE_N=OE_N=WE_N=1, UB_N=LB_N=1, SRAM_DQ=Z, SRAM_ADDR holds its last value.
- ready = (IDLE and not (rd_en or wr_en)) or DONE. This is combinational from state and requests, so the pipeline freezes in the same cycle the request appears.
- rd_data holds its value until the next read overwrites it. Write accesses do not alter rd_data.

## Timing
- Reset values: state=IDLE, k=w=0, rd_data=0, SRAM_ADDR=0, CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_DQ=Z, ready=1 (with no request).
- All SRAM control outputs, SRAM_ADDR and the DQ drive are registered. There are no glitches between beats, and WE_N rises before SRAM_ADDR changes.
- Latency:
  - Request sampled at edge 0.
  - ACCESS occupies BEATS·(WAIT_CYCLES+1) cycles.
  - DONE (ready=1) in the following cycle.
  - Default parameters: ready low for 12 cycles, high in the 13th.
- The requester must drop its request in the DONE cycle. A request still high in IDLE after DONE starts a new access.
- Changes to address/wr_data/byte_en during ACCESS are ignored (latched copies are used).
- rst asserted mid-access: at the next edge, go to IDLE with all reset values, abort the current beat and release DQ. A partially written word remains partially written.
- back-to-back: the earliest next request is sampled in the IDLE cycle right after DONE.

## Test plan
- Reset: hold rst 2 cycles, with rd_en=wr_en=0 after reset → ready=1, WE_N=CE_N=1, DQ=Z, rd_data=0.
- Full write, defaults: wr_en, address=1024, wr_data=0xDEADBEEF, byte_en=4'hF → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready low 12 cycles, high on the 13th; WE_N low exactly 5 cycles per beat.
- Read back: rd_en, address=1024 → rd_data=0xDEADBEEF in DONE; OE_N=0 and DQ=Z throughout ACCESS.
- Partial write: preload SRAM[3]=0x1234; wr_en, address=1028, wr_data=0x00AA0000, byte_en=4'b0100 → beat 1 has LB_N=0, UB_N=1, SRAM[3]=0x12AA; SRAM[2] is unchanged.
- Reset mid-write: assert rst at cycle 3 of beat 0 → next edge WE_N=1, DQ=Z, ready=1; a following read completes normally.
- Parameter sweep: CPU_DW=64, WAIT_CYCLES=1, write 0x0123456789ABCDEF at 1024 → SRAM[0..3]=0xCDEF, 0x89AB, 0x4567, 0x0123; latency 8 cycles + DONE.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges one CPU_DW-wide CPU memory request onto a 16-bit
// asynchronous SRAM as CPU_DW/16 sequential halfword beats. Each beat lasts
// WAIT_CYCLES+1 clocks. All SRAM pins are registered so they change cleanly
// on clock edges only.
module sram_ctrl #(
    parameter int CPU_DW      = 32,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [31:0]           address,
    input  logic [CPU_DW-1:0]     wr_data,
    input  logic [CPU_DW/8-1:0]   byte_en,
    output logic [CPU_DW-1:0]     rd_data,
    output logic                  ready,
    inout  wire  [15:0]           SRAM_DQ,
    output logic [SRAM_AW-1:0]    SRAM_ADDR,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N
);

    localparam int BEATS = CPU_DW / 16;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = $clog2(WAIT_CYCLES + 1);
    localparam int SHIFT = $clog2(CPU_DW / 8);

    localparam logic [KW-1:0] KMAX = KW'(BEATS - 1);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [WW-1:0]         w_q, w_d;

    // Latched request (valid from the IDLE->ACCESS edge onwards)
    logic                  op_we_q, op_we_d;
    logic [31:0]           addr_q, addr_d;
    logic [CPU_DW-1:0]     wdata_q, wdata_d;
    logic [CPU_DW/8-1:0]   be_q, be_d;

    logic [CPU_DW-1:0]     rd_data_q;

    // Registered SRAM pins
    logic [SRAM_AW-1:0]    sram_addr_q, sram_addr_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  ub_n_q, ub_n_d;
    logic                  lb_n_q, lb_n_d;
    logic                  dq_oe_q, dq_oe_d;
    logic [15:0]           dq_out_q, dq_out_d;

    // Halfword address of the beat about to be presented.
    logic [31:0]           beat_addr;
    assign beat_addr = ((addr_d - 32'(ADDR_BASE)) >> SHIFT) * 32'(BEATS) + 32'(k_d);

    // Next-state logic: request latch, beat and wait counters.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        op_we_d = op_we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = ACCESS;
                    k_d     = '0;
                    w_d     = '0;
                    op_we_d = wr_en;  // write wins if both are raised
                    addr_d  = address;
                    wdata_d = wr_data;
                    be_d    = byte_en;
                end
            end
            ACCESS: begin
                if (w_q == WMAX) begin
                    w_d = '0;
                    if (k_q == KMAX) state_d = DONE;
                    else             k_d     = k_q + KW'(1);
                end else begin
                    w_d = w_q + WW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values for the next cycle, derived from the next state so the pins are registered.
    always_comb begin
        sram_addr_d = sram_addr_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        if (state_d == ACCESS) begin
            sram_addr_d = SRAM_AW'(beat_addr);
            ce_n_d      = 1'b0;
            if (op_we_d) begin
                // WE_N rises on the last wait cycle so data and address are held past it.
                we_n_d             = (w_d == WMAX);
                {ub_n_d, lb_n_d}   = ~(2'(be_d >> {k_d, 1'b0}));
                dq_oe_d            = 1'b1;
                dq_out_d           = 16'(wdata_d >> {k_d, 4'b0000});
            end else begin
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
        end
    end

    // State, counters, SRAM pins and read-data capture, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            w_q         <= '0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            k_q         <= k_d;
            w_q         <= w_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
            if (state_q == ACCESS && !op_we_q && w_q == WMAX) begin
                rd_data_q[{k_q, 4'b0000} +: 16] <= SRAM_DQ;
            end
        end
    end

    // Request capture registers.
    always_ff @(posedge clk) begin
        // NOTE: left unreset on purpose; they are only consumed in ACCESS, which always loads them first.
        op_we_q <= op_we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Simultaneous read and write requests violate the protocol (write wins).
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE) begin
            a_rd_wr_exclusive: assert (!(rd_en && wr_en));
        end
    end

    assign ready     = (state_q == IDLE && !(rd_en || wr_en)) || (state_q == DONE);
    assign rd_data   = rd_data_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a default instance (32-bit, 5 wait cycles)
// and a 64-bit / 1-wait instance, each backed by a small behavioural SRAM.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Default instance
    logic        wr_en0, rd_en0, ready0;
    logic [31:0] address0, wr_data0, rd_data0;
    logic [3:0]  byte_en0;
    wire  [15:0] dq0;
    logic [17:0] sa0;
    logic        ub0_n, lb0_n, we0_n, ce0_n, oe0_n;
    logic [15:0] mem0 [64];

    // 64-bit, 1-wait instance
    logic        wr_en1, rd_en1, ready1;
    logic [31:0] address1;
    logic [63:0] wr_data1, rd_data1;
    logic [7:0]  byte_en1;
    wire  [15:0] dq1;
    logic [17:0] sa1;
    logic        ub1_n, lb1_n, we1_n, ce1_n, oe1_n;
    logic [15:0] mem1 [64];

    sram_ctrl u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
        .wr_data(wr_data0), .byte_en(byte_en0), .rd_data(rd_data0), .ready(ready0),
        .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_UB_N(ub0_n), .SRAM_LB_N(lb0_n),
        .SRAM_WE_N(we0_n), .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe0_n)
    );

    sram_ctrl #(.CPU_DW(64), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
        .wr_data(wr_data1), .byte_en(byte_en1), .rd_data(rd_data1), .ready(ready1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n),
        .SRAM_WE_N(we1_n), .SRAM_CE_N(ce1_n), .SRAM_OE_N(oe1_n)
    );

    // Behavioural asynchronous SRAMs: drive on read, byte-masked write while WE_N is low.
    assign dq0 = (!ce0_n && !oe0_n && we0_n) ? mem0[sa0[5:0]] : 16'hzzzz;
    assign dq1 = (!ce1_n && !oe1_n && we1_n) ? mem1[sa1[5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce0_n && !we0_n) begin
            if (!lb0_n) mem0[sa0[5:0]][7:0]  <= dq0[7:0];
            if (!ub0_n) mem0[sa0[5:0]][15:8] <= dq0[15:8];
        end
        if (!ce1_n && !we1_n) begin
            if (!lb1_n) mem1[sa1[5:0]][7:0]  <= dq1[7:0];
            if (!ub1_n) mem1[sa1[5:0]][15:8] <= dq1[15:8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access on the default instance. Starts and ends 1 time unit after an edge.
    task automatic run0(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int low, output int we_b0, output int we_b1, output int oe_cnt,
                        output logic [17:0] a_b0, output logic [17:0] a_b1,
                        output logic [1:0] ublb_b0, output logic [1:0] ublb_b1,
                        output logic [31:0] rd);
        low = 0; we_b0 = 0; we_b1 = 0; oe_cnt = 0;
        a_b0 = '0; a_b1 = '0; ublb_b0 = '0; ublb_b1 = '0; rd = '0;
        wr_en0 = we; rd_en0 = !we; address0 = a; wr_data0 = d; byte_en0 = be;
        #1;
        check({tag, "_ready_same_cycle"}, 64'(ready0), 64'd0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c <= 12) begin
                if (!ready0) low++;
                if (!we0_n) begin
                    if (c <= 6) we_b0++;
                    else        we_b1++;
                end
                if (!oe0_n) oe_cnt++;
                if (c == 1) begin a_b0 = sa0; ublb_b0 = {ub0_n, lb0_n}; end
                if (c == 7) begin a_b1 = sa0; ublb_b1 = {ub0_n, lb0_n}; end
            end else begin
                check({tag, "_ready_done"}, 64'(ready0), 64'd1);
                rd = rd_data0;
                wr_en0 = 1'b0;
                rd_en0 = 1'b0;
            end
        end
        tick();
    endtask

    int          low, we_b0, we_b1, oe_cnt;
    logic [17:0] a_b0, a_b1;
    logic [1:0]  ublb_b0, ublb_b1;
    logic [31:0] rd;

    initial begin
        rst = 1'b1;
        wr_en0 = 0; rd_en0 = 0; address0 = '0; wr_data0 = '0; byte_en0 = '0;
        wr_en1 = 0; rd_en1 = 0; address1 = '0; wr_data1 = '0; byte_en1 = '0;

        // Reset held two cycles
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(ready0), 64'd1);
        check("rst_we_n",  64'(we0_n),  64'd1);
        check("rst_ce_n",  64'(ce0_n),  64'd1);
        check("rst_oe_n",  64'(oe0_n),  64'd1);
        check("rst_ublb",  64'({ub0_n, lb0_n}), 64'd3);
        check("rst_rd_data", 64'(rd_data0), 64'd0);
        check("rst_sram_addr", 64'(sa0), 64'd0);
        n_checks++;
        assert (dq0 === 16'hzzzz) n_pass++;
        else begin n_fail++; $error("FAIL rst_dq: observed %h expected zzzz", dq0); end
        tick();

        // Full write 0xDEADBEEF at 1024
        run0("wr", 1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, low, we_b0, we_b1, oe_cnt, a_b0, a_b1, ublb_b0, ublb_b1, rd);
        check("wr_ready_low_cycles", 64'(low), 64'd12);
        check("wr_we_low_beat0", 64'(we_b0), 64'd5);
        check("wr_we_low_beat1", 64'(we_b1), 64'd5);
        check("wr_addr_beat0", 64'(a_b0), 64'd0);
        check("wr_addr_beat1", 64'(a_b1), 64'd1);
        check("wr_ublb_beat0", 64'(ublb_b0), 64'd0);
        check("wr_mem0", 64'(mem0[0]), 64'hBEEF);
        check("wr_mem1", 64'(mem0[1]), 64'hDEAD);

        // Read back
        run0("rd", 1'b0, 32'd1024, 32'h0, 4'h0, low, we_b0, we_b1, oe_cnt, a_b0, a_b1, ublb_b0, ublb_b1, rd);
        check("rd_ready_low_cycles", 64'(low), 64'd12);
        check("rd_oe_low_cycles", 64'(oe_cnt), 64'd12);
        check("rd_we_low", 64'(we_b0 + we_b1), 64'd0);
        check("rd_data", 64'(rd), 64'hDEADBEEF);

        // Preload SRAM[2]=0x5555, SRAM[3]=0x1234; rd_data must survive the write
        run0("pre", 1'b1, 32'd1028, 32'h12345555, 4'hF, low, we_b0, we_b1, oe_cnt, a_b0, a_b1, ublb_b0, ublb_b1, rd);
        check("pre_rd_data_kept", 64'(rd), 64'hDEADBEEF);

        // Partial write: only byte 2
        run0("pw", 1'b1, 32'd1028, 32'h00AA0000, 4'b0100, low, we_b0, we_b1, oe_cnt, a_b0, a_b1, ublb_b0, ublb_b1, rd);
        check("pw_addr_beat0", 64'(a_b0), 64'd2);
        check("pw_ublb_beat0", 64'(ublb_b0), 64'b11);
        check("pw_ublb_beat1", 64'(ublb_b1), 64'b10);
        check("pw_mem2", 64'(mem0[2]), 64'h5555);
        check("pw_mem3", 64'(mem0[3]), 64'h12AA);

        // Reset in cycle 3 of beat 0 of a write
        wr_en0 = 1'b1; address0 = 32'd1032; wr_data0 = 32'hCAFEF00D; byte_en0 = 4'hF;
        tick();
        tick();
        tick();
        check("mr_we_before", 64'(we0_n), 64'd0);
        rst = 1'b1;
        wr_en0 = 1'b0;
        tick();
        check("mr_we_n", 64'(we0_n), 64'd1);
        check("mr_ce_n", 64'(ce0_n), 64'd1);
        check("mr_ready", 64'(ready0), 64'd1);
        n_checks++;
        assert (dq0 === 16'hzzzz) n_pass++;
        else begin n_fail++; $error("FAIL mr_dq: observed %h expected zzzz", dq0); end
        rst = 1'b0;
        tick();
        check("mr_mem4_partial", 64'(mem0[4]), 64'hF00D);

        // Read after the aborted write
        run0("rd2", 1'b0, 32'd1028, 32'h0, 4'h0, low, we_b0, we_b1, oe_cnt, a_b0, a_b1, ublb_b0, ublb_b1, rd);
        check("rd2_ready_low_cycles", 64'(low), 64'd12);
        check("rd2_data", 64'(rd), 64'h12AA5555);

        // 64-bit, 1 wait cycle instance
        wr_en1 = 1'b1; address1 = 32'd1024; wr_data1 = 64'h0123456789ABCDEF; byte_en1 = 8'hFF;
        #1;
        check("sw_ready_same_cycle", 64'(ready1), 64'd0);
        low = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 8) begin
                if (!ready1) low++;
            end else begin
                check("sw_ready_done", 64'(ready1), 64'd1);
                wr_en1 = 1'b0;
            end
        end
        tick();
        check("sw_ready_low_cycles", 64'(low), 64'd8);
        check("sw_mem0", 64'(mem1[0]), 64'hCDEF);
        check("sw_mem1", 64'(mem1[1]), 64'h89AB);
        check("sw_mem2", 64'(mem1[2]), 64'h4567);
        check("sw_mem3", 64'(mem1[3]), 64'h0123);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
